xcvr_8b10b_link_ctrl: RTL

Per-channel link bring-up and monitoring controller for one channel of the Arria 10 8B/10B native transceiver (16-bit parallel, 2-bit K flags).
- Waits for reset-controller tx/rx ready, then drives word-alignment requests and qualifies lock.
- Transmits K28.5 idle until the link is up, then passes user traffic.
- Monitors decode errors and forces re-alignment when the link degrades.
- Instantiated once per channel, between user logic and the transceiver IP. TX/RX core clocks are tied to the single controller clock.

---
 rtl/xcvr_8b10b_pkg.sv | 20 ++
 rtl/xcvr_8b10b_link_ctrl_err_mon.sv | 46 ++++
 rtl/xcvr_8b10b_link_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/xcvr_8b10b_pkg.sv
// Shared link-state encoding and 8B/10B idle/comma constants for the link controller.
package xcvr_8b10b_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        ALIGN      = 2'd1,
        LOCKING    = 2'd2,
        LINK_UP    = 2'd3
    } link_state_e;

    localparam logic [7:0]  K28_5           = 8'hBC;
    localparam logic [7:0]  D21_5           = 8'hB5;
    localparam logic [15:0] IDLE_WORD_DEF   = {D21_5, K28_5};
    localparam logic [1:0]  IDLE_DATAK_DEF  = 2'b01;

    function automatic logic [2:0] state_to_port(input link_state_e s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/xcvr_8b10b_link_ctrl_err_mon.sv
// RX word error qualification plus LINK_UP error-window/threshold tracking.
// Counters run only while en is high and are held cleared otherwise.
module xcvr_8b10b_err_mon #(
    parameter int ERR_WINDOW = 256,
    parameter int ERR_THRESH = 4
) (
    input  logic       clk_clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] rx_syncstatus,
    input  logic [1:0] rx_errdetect,
    input  logic [1:0] rx_disperr,
    output logic       word_err,
    output logic       degrade
);

    localparam int WIN_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int CNT_W = $clog2(ERR_THRESH + 1);
    localparam int INC_W = CNT_W + 1;

    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic [INC_W-1:0] inc;

    always_comb begin
        word_err = (|rx_errdetect) | (|rx_disperr) | ~(&rx_syncstatus);
        wrap     = (win_q == WIN_W'(ERR_WINDOW - 1));
        // An error landing on the wrap cycle opens the new window's tally.
        inc      = (wrap ? '0 : {1'b0, cnt_q}) + INC_W'(word_err);
        degrade  = en & word_err & (inc >= INC_W'(ERR_THRESH));
        win_d    = wrap ? '0 : win_q + 1'b1;
        cnt_d    = inc[CNT_W-1:0];
    end

    always_ff @(posedge clk_clk) begin
        if (!rst_n || !en) begin
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xcvr_8b10b_link_ctrl.sv
// Per-channel 8B/10B link bring-up/monitor controller (idle until lock, then user traffic).
// Optional LINK_STATS_EN macro adds saturating relink and error totals.
module xcvr_8b10b_link_ctrl
    import xcvr_8b10b_pkg::*;
#(
    parameter int          LOCK_CYCLES   = 64,
    parameter int          ERR_WINDOW    = 256,
    parameter int          ERR_THRESH    = 4,
    parameter int          ALIGN_TIMEOUT = 4096,
    parameter logic [15:0] IDLE_WORD     = IDLE_WORD_DEF,
    parameter logic [1:0]  IDLE_DATAK    = IDLE_DATAK_DEF
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        tx_ready,
    input  logic        rx_ready,
    input  logic [15:0] rx_parallel_data,
    input  logic [1:0]  rx_datak,
    input  logic [1:0]  rx_syncstatus,
    input  logic [1:0]  rx_errdetect,
    input  logic [1:0]  rx_disperr,
    output logic        rx_std_wa_patternalign,
    output logic [15:0] tx_parallel_data,
    output logic [1:0]  tx_datak,
    input  logic [15:0] user_tx_data,
    input  logic [1:0]  user_tx_datak,
    output logic        user_tx_ready,
    output logic [15:0] user_rx_data,
    output logic [1:0]  user_rx_datak,
    output logic        user_rx_valid,
    output logic        link_up,
    output logic [2:0]  link_state
`ifdef LINK_STATS_EN
    ,
    output logic [15:0] relink_count,
    output logic [15:0] err_total
`endif
);

    localparam int CLEAN_W = $clog2(LOCK_CYCLES + 1);
    localparam int TO_W    = (ALIGN_TIMEOUT > 1) ? $clog2(ALIGN_TIMEOUT) : 1;

    link_state_e        state_q, state_d;
    logic               pa_q, pa_d;
    logic [CLEAN_W-1:0] clean_q, clean_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [15:0]        tx_data_q;
    logic [1:0]         tx_datak_q;
    logic               tx_rdy_q;
    logic [15:0]        rx_data_q;
    logic [1:0]         rx_datak_q;
    logic               rx_valid_q;
    logic               link_up_q;
    logic               word_err;
    logic               degrade;
    logic               stay_up;

    xcvr_8b10b_err_mon #(
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) u_err_mon (
        .clk_clk       (clk_clk),
        .rst_n         (reset_reset_n),
        .en            (state_q == LINK_UP),
        .rx_syncstatus (rx_syncstatus),
        .rx_errdetect  (rx_errdetect),
        .rx_disperr    (rx_disperr),
        .word_err      (word_err),
        .degrade       (degrade)
    );

    always_comb begin
        state_d = state_q;
        pa_d    = 1'b0;
        clean_d = '0;
        to_d    = '0;
        if (!(tx_ready && rx_ready)) begin
            state_d = RESET_WAIT;
        end else begin
            case (state_q)
                RESET_WAIT: begin
                    state_d = ALIGN;
                    pa_d    = 1'b1;
                end
                ALIGN: begin
                    if (!word_err) begin
                        state_d = LOCKING;
                        clean_d = CLEAN_W'(1);
                    end else if (to_q == TO_W'(ALIGN_TIMEOUT - 1)) begin
                        pa_d = 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                LOCKING: begin
                    if (word_err) begin
                        state_d = ALIGN;
                        pa_d    = 1'b1;
                    end else if (clean_q >= CLEAN_W'(LOCK_CYCLES - 1)) begin
                        state_d = LINK_UP;
                    end else begin
                        clean_d = clean_q + 1'b1;
                    end
                end
                LINK_UP: begin
                    if (degrade) begin
                        state_d = ALIGN;
                        pa_d    = 1'b1;
                    end
                end
                default: state_d = RESET_WAIT;
            endcase
        end
        // User traffic flows only on cycles that both start and end in LINK_UP.
        stay_up = (state_q == LINK_UP) && (state_d == LINK_UP);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= RESET_WAIT;
            pa_q       <= 1'b0;
            clean_q    <= '0;
            to_q       <= '0;
            tx_data_q  <= IDLE_WORD;
            tx_datak_q <= IDLE_DATAK;
            tx_rdy_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_datak_q <= '0;
            rx_valid_q <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pa_q       <= pa_d;
            clean_q    <= clean_d;
            to_q       <= to_d;
            tx_data_q  <= stay_up ? user_tx_data  : IDLE_WORD;
            tx_datak_q <= stay_up ? user_tx_datak : IDLE_DATAK;
            tx_rdy_q   <= (state_d == LINK_UP);
            rx_data_q  <= rx_parallel_data;
            rx_datak_q <= rx_datak;
            rx_valid_q <= stay_up & ~word_err;
            link_up_q  <= (state_d == LINK_UP);
        end
    end

`ifdef LINK_STATS_EN
    logic [15:0] relink_q;
    logic [15:0] err_total_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            relink_q    <= '0;
            err_total_q <= '0;
        end else begin
            if ((state_q == LINK_UP) && (state_d != LINK_UP) && (relink_q != 16'hFFFF))
                relink_q <= relink_q + 16'd1;
            if ((state_q == LINK_UP) && word_err && (err_total_q != 16'hFFFF))
                err_total_q <= err_total_q + 16'd1;
        end
    end

    assign relink_count = relink_q;
    assign err_total    = err_total_q;
`endif

    assign rx_std_wa_patternalign = pa_q;
    assign tx_parallel_data       = tx_data_q;
    assign tx_datak               = tx_datak_q;
    assign user_tx_ready          = tx_rdy_q;
    assign user_rx_data           = rx_data_q;
    assign user_rx_datak          = rx_datak_q;
    assign user_rx_valid          = rx_valid_q;
    assign link_up                = link_up_q;
    assign link_state             = state_to_port(state_q);

endmodule
